frame_read_buffer: RTL and testbench

Upstream feeder for the LCD video timing stage. On each frame-start request it prefetches one frame of pixels from the SDRAM read port in bursts into an internal FIFO, and returns one word per read_en with fixed one-cycle latency. Single clock domain (video_clk); the SDRAM-side arbiter is already synchronised to video_clk.

---
 rtl/frame_read_buffer.sv | 190 +++++++++++++++++++
 tb/tb_frame_read_buffer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_buffer.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_buffer
// Purpose  : Prefetches one video frame from the SDRAM read port in bursts
//            into a local FIFO and hands pixels to the LCD timing stage with
//            a fixed one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module frame_read_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 24,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 130560,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  read_req,
  output logic                  read_req_ack,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [9:0]            mem_rd_len,
  input  logic                  mem_rd_ack,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  underflow,
  output logic                  overflow
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_REM_W = $clog2(FRAME_WORDS + 1);

  localparam logic [c_CNT_W-1:0]    c_DEPTH = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0]    c_BURST = c_CNT_W'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] c_BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [c_REM_W-1:0]    c_FRAME = c_REM_W'(FRAME_WORDS);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_ACK  = 3'd1;
  localparam logic [2:0] c_REQ  = 3'd2;
  localparam logic [2:0] c_DATA = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [c_REM_W-1:0]    r_remaining;
  logic [9:0]            r_burst_cnt;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_in_ack;
  logic                  w_in_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_space_ok;
  logic                  w_last_word;
  logic [9:0]            w_len;

  assign w_in_ack     = (r_state == c_ACK);
  assign w_in_data    = (r_state == c_DATA);
  assign w_full       = (r_count == c_DEPTH);
  assign w_empty      = (r_count == '0);
  // Words arriving with the FIFO full are dropped; only DATA-state words are stored.
  assign w_push       = w_in_data && mem_rd_valid && !w_full;
  // The ACK cycle flushes the FIFO, so nothing is popped there.
  assign w_pop        = read_en && !w_empty && !w_in_ack;
  assign w_space_ok   = ((c_DEPTH - r_count) >= c_BURST);
  assign w_last_word  = w_in_data && mem_rd_valid && (r_burst_cnt == (mem_rd_len - 10'd1));
  assign read_req_ack = w_in_ack;

  // Burst length: a full burst, or whatever is left of the frame.
  always_comb begin
    w_len = 10'(BURST_LEN);
    if (32'(r_remaining) < 32'(BURST_LEN)) begin
      w_len = 10'(r_remaining);
    end
  end

  // Frame sequencing FSM and SDRAM burst request side.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_addr      <= c_BASE;
      r_remaining <= '0;
      r_burst_cnt <= '0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      mem_rd_len  <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (read_req) begin
            r_state <= c_ACK;
          end
        end
        c_ACK: begin
          r_addr      <= c_BASE;
          r_remaining <= c_FRAME;
          r_state     <= c_REQ;
        end
        c_REQ: begin
          if (mem_rd_req) begin
            // Once a burst is requested it is committed until acknowledged.
            if (mem_rd_ack) begin
              mem_rd_req  <= 1'b0;
              r_burst_cnt <= '0;
              r_state     <= c_DATA;
            end
          end else if (read_req) begin
            r_state <= c_ACK;
          end else if (r_remaining == '0) begin
            r_state <= c_DONE;
          end else if (w_space_ok) begin
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= r_addr;
            mem_rd_len  <= w_len;
          end
        end
        c_DATA: begin
          if (w_last_word) begin
            r_addr      <= r_addr + ADDR_WIDTH'(mem_rd_len);
            r_remaining <= r_remaining - c_REM_W'(mem_rd_len);
            r_state     <= c_REQ;
          end else if (mem_rd_valid) begin
            r_burst_cnt <= r_burst_cnt + 10'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; the ACK cycle empties the buffer.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_in_ack) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the count says empty.
  always_ff @(posedge video_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mem_rd_data;
    end
  end

  // Registered read port and error pulses.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      read_data <= w_pop ? r_mem[r_rd_ptr] : '0;
      underflow <= read_en && w_empty;
      overflow  <= mem_rd_valid && w_full;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_read_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_read_buffer
// Purpose  : Self-checking bench for frame_read_buffer: directed vectors,
//            corner-case sequences and randomized traffic against a
//            queue-based reference model and a simple SDRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_read_buffer;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int FW = 100;
  localparam int BL = 32;
  localparam int FD = 64;

  logic          video_clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_req = 1'b0;
  logic          read_req_ack;
  logic          read_en = 1'b0;
  logic [DW-1:0] read_data;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [9:0]    mem_rd_len;
  logic          mem_rd_ack = 1'b0;
  logic          mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          underflow;
  logic          overflow;

  always #5 video_clk = ~video_clk;

  frame_read_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0),
    .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .video_clk(video_clk), .rst(rst),
    .read_req(read_req), .read_req_ack(read_req_ack),
    .read_en(read_en), .read_data(read_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .underflow(underflow), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SDRAM responder ----------------
  bit      gaps = 1'b0;
  bit      mm_busy = 1'b0;
  int      mm_wait = 0;
  int      mm_addr = 0;
  int      mm_len = 0;
  int      mm_idx = 0;

  // Called once per cycle just after the rising edge: ack two cycles after a
  // request, then stream len words whose value equals their address.
  task automatic mem_drive();
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    if (mem_rd_ack) begin
      mem_rd_ack = 1'b0;
      mm_busy    = 1'b1;
      mm_idx     = 0;
    end else if (!mm_busy && mem_rd_req) begin
      mm_wait++;
      if (mm_wait >= 2) begin
        mem_rd_ack = 1'b1;
        mm_addr    = int'(mem_rd_addr);
        mm_len     = int'(mem_rd_len);
        mm_wait    = 0;
      end
    end
    if (mm_busy && (!gaps || $urandom_range(3) != 0)) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = DW'(mm_addr + mm_idx);
      mm_idx++;
      if (mm_idx == mm_len) mm_busy = 1'b0;
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] q[$];
  int  issued = 0;
  int  bursts = 0;
  int  m_left = 0;
  bit  in_burst = 1'b0;
  bit  prev_ack = 1'b0;
  bit  prev_req = 1'b0;

  task automatic reset_model();
    q.delete();
    issued = 0; bursts = 0; m_left = 0; in_burst = 1'b0;
    prev_ack = 1'b0; prev_req = 1'b0;
    mm_busy = 1'b0; mm_wait = 0; mm_idx = 0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  // One clock cycle: observe pins at the falling edge, predict, let the
  // rising edge happen, compare, then let the memory react.
  task automatic tick();
    logic [DW-1:0] e_rd;
    bit e_uf, e_ov, full, empty;
    int e_len;
    @(negedge video_clk);
    full  = (q.size() == FD);
    empty = (q.size() == 0);
    if (read_req_ack) begin
      chk("ack_outside_burst", {31'd0, in_burst}, 32'd0);
      chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
    end
    if (mem_rd_req && !prev_req) begin
      chk("req_free_space", ((FD - q.size()) >= BL) ? 32'd1 : 32'd0, 32'd1);
      chk("req_frame_left", (issued < FW) ? 32'd1 : 32'd0, 32'd1);
    end
    e_ov = mem_rd_valid && full;
    e_uf = read_en && empty;
    e_rd = '0;
    if (read_en && !empty && !read_req_ack) e_rd = q.pop_front();
    if (read_req_ack) begin
      q.delete();
      issued = 0;
      bursts = 0;
    end
    if (in_burst && mem_rd_valid) begin
      if (!full) q.push_back(mem_rd_data);
      m_left--;
      if (m_left == 0) in_burst = 1'b0;
    end
    if (mem_rd_req && mem_rd_ack) begin
      e_len = (FW - issued < BL) ? FW - issued : BL;
      chk("burst_addr", 32'(mem_rd_addr), 32'(issued));
      chk("burst_len", 32'(mem_rd_len), 32'(e_len));
      in_burst = 1'b1;
      m_left   = int'(mem_rd_len);
      issued  += int'(mem_rd_len);
      bursts++;
    end
    prev_ack = read_req_ack;
    prev_req = mem_rd_req;
    @(posedge video_clk);
    #1;
    chk("read_data", 32'(read_data), 32'(e_rd));
    chk("underflow", {31'd0, underflow}, {31'd0, e_uf});
    chk("overflow", {31'd0, overflow}, {31'd0, e_ov});
    mem_drive();
  endtask

  // Raise read_req and hold it until the acknowledge is seen.
  task automatic request_frame();
    bit got = 1'b0;
    read_req = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      got = read_req_ack;
    end
    read_req = 1'b0;
    chk("req_ack_seen", {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    bit rr;
    bit re;
    bit exp_ack;
    bit exp_req;
    bit chk_al;
    int exp_addr;
    int exp_len;
    bit exp_uf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int got, ufs, reqs, left_at_req, seen;
    bit hit;
    int rr_wait, ren_pct;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_ack", {31'd0, read_req_ack}, 32'd0);
    chk("rst_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_len", 32'(mem_rd_len), 32'd0);
    chk("rst_data", 32'(read_data), 32'd0);
    chk("rst_uf_ov", {30'd0, underflow, overflow}, 32'd0);
    repeat (2) @(posedge video_clk);
    #1 rst = 1'b0;
    reset_model();

    // Directed vectors: handshake and first burst request
    vecs[0] = '{rr:1, re:1, exp_ack:1, exp_req:0, chk_al:0, exp_addr:0, exp_len:0,  exp_uf:1};
    vecs[1] = '{rr:0, re:0, exp_ack:0, exp_req:0, chk_al:0, exp_addr:0, exp_len:0,  exp_uf:0};
    vecs[2] = '{rr:0, re:1, exp_ack:0, exp_req:1, chk_al:1, exp_addr:0, exp_len:32, exp_uf:1};
    vecs[3] = '{rr:0, re:1, exp_ack:0, exp_req:1, chk_al:1, exp_addr:0, exp_len:32, exp_uf:1};
    vecs[4] = '{rr:0, re:0, exp_ack:0, exp_req:0, chk_al:0, exp_addr:0, exp_len:0,  exp_uf:0};
    for (int i = 0; i < 5; i++) begin
      read_req = vecs[i].rr;
      read_en  = vecs[i].re;
      tick();
      chk($sformatf("vec%0d_ack", i), {31'd0, read_req_ack}, {31'd0, vecs[i].exp_ack});
      chk($sformatf("vec%0d_req", i), {31'd0, mem_rd_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_uf", i), {31'd0, underflow}, {31'd0, vecs[i].exp_uf});
      chk($sformatf("vec%0d_data", i), 32'(read_data), 32'd0);
      if (vecs[i].chk_al) begin
        chk($sformatf("vec%0d_addr", i), 32'(mem_rd_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_len", i), 32'(mem_rd_len), 32'(vecs[i].exp_len));
      end
    end
    read_en = 1'b0;

    // Free-space gating: only two bursts before any read
    repeat (150) tick();
    chk("gate_bursts", 32'(bursts), 32'd2);
    chk("gate_no_req", {31'd0, mem_rd_req}, 32'd0);

    // Continuous read of the whole frame
    read_en = 1'b1;
    for (int i = 0; i < FW; i++) begin
      tick();
      chk("frameA_word", 32'(read_data), 32'(i));
    end
    read_en = 1'b0;
    repeat (5) tick();
    chk("frameA_bursts", 32'(bursts), 32'd4);

    // Reads from an empty FIFO right after the acknowledge
    request_frame();
    read_en = 1'b1;
    got = 0; ufs = 0;
    for (int k = 0; k < 1000 && got < FW; k++) begin
      tick();
      if (underflow) ufs++;
      else begin
        chk("frameB_word", 32'(read_data), 32'(got));
        got++;
      end
    end
    chk("frameB_count", 32'(got), 32'(FW));
    chk("frameB_underflowed", (ufs > 0) ? 32'd1 : 32'd0, 32'd1);
    read_en = 1'b0;

    // Push and pop together at 63 words, then gating at 63
    request_frame();
    repeat (120) tick();
    reqs = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_rd_req) reqs++;
    end
    chk("full_no_req", 32'(reqs), 32'd0);
    read_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("frameC_head", 32'(read_data), 32'(i));
    end
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      // Pop exactly when the last word of the third burst is on the bus.
      read_en = (mem_rd_valid && !mm_busy && mm_addr == 64) ? 1'b1 : 1'b0;
      hit = read_en;
      tick();
    end
    read_en = 1'b0;
    chk("simul_hit", {31'd0, hit}, 32'd1);
    chk("simul_word", 32'(read_data), 32'd32);
    reqs = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (mem_rd_req) reqs++;
    end
    chk("at63_no_req", 32'(reqs), 32'd0);
    read_en = 1'b1;
    for (int i = 33; i < FW; i++) begin
      tick();
      chk("frameC_tail", 32'(read_data), 32'(i));
    end
    tick();
    chk("frameC_empty_uf", {31'd0, underflow}, 32'd1);
    read_en = 1'b0;

    // Protocol violation: data while full is dropped
    request_frame();
    repeat (120) tick();
    mem_rd_valid = 1'b1;
    mem_rd_data  = 16'hBEEF;
    tick();
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    tick();
    chk("ovf_single", {31'd0, overflow}, 32'd0);
    read_en = 1'b1;
    for (int i = 0; i < FD; i++) begin
      tick();
      chk("ovf_kept", 32'(read_data), 32'(i));
    end
    read_en = 1'b0;
    repeat (80) tick();

    // New request during the second burst
    request_frame();
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      tick();
      hit = (bursts == 2 && in_burst && m_left <= 20);
    end
    chk("mid_burst2", {31'd0, hit}, 32'd1);
    left_at_req = m_left;
    seen = 0;
    read_req = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (mem_rd_valid) seen++;
      tick();
      hit = read_req_ack;
      if (hit) chk("ack_after_last_word", 32'(seen), 32'(left_at_req));
    end
    read_req = 1'b0;
    chk("restart_ack", {31'd0, hit}, 32'd1);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      tick();
      hit = mem_rd_req;
    end
    chk("restart_req", {31'd0, hit}, 32'd1);
    chk("restart_addr", 32'(mem_rd_addr), 32'd0);
    repeat (45) tick();
    read_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("restart_word", 32'(read_data), 32'(i));
    end
    read_en = 1'b0;

    // Asynchronous reset in the middle of a burst
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      tick();
      hit = mm_busy;
    end
    chk("mid_burst_seen", {31'd0, hit}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_rd_req}, 32'd0);
    chk("arst_ack", {31'd0, read_req_ack}, 32'd0);
    chk("arst_addr_len", 32'(mem_rd_addr) | 32'(mem_rd_len), 32'd0);
    chk("arst_data", 32'(read_data), 32'd0);
    reset_model();
    @(posedge video_clk);
    #1 rst = 1'b0;
    read_en = 1'b1;
    tick();
    chk("arst_empty_uf", {31'd0, underflow}, 32'd1);
    read_en = 1'b0;
    request_frame();
    repeat (100) tick();
    read_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst_frame_word", 32'(read_data), 32'(i));
    end

    // Randomized traffic against the model
    gaps = 1'b1;
    rr_wait = 0;
    for (int blk = 0; blk < 6; blk++) begin
      ren_pct = 20 + 15 * blk;
      for (int k = 0; k < 500; k++) begin
        read_en = ($urandom_range(99) < ren_pct) ? 1'b1 : 1'b0;
        if (!read_req && $urandom_range(199) == 0) begin
          read_req = 1'b1;
          rr_wait  = 0;
        end
        tick();
        if (read_req) begin
          rr_wait++;
          if (read_req_ack) read_req = 1'b0;
          else if (rr_wait > 400) begin
            chk("rand_ack_timeout", 32'(rr_wait), 32'd0);
            read_req = 1'b0;
          end
        end
      end
    end
    read_en = 1'b0;
    read_req = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
